// File: rtl/display_raster_pingpong.sv
`default_nettype none
// ============================================================================
// display_raster_pingpong
// Packs write words into two ping-pong pixel banks and raster-scans a full bank
// out with run-time blanking; repeats the current frame when the next is late.
// Revision: 1.0
// ============================================================================
module display_raster_pingpong #(
  parameter int DW    = 8,
  parameter int WW    = 32,
  parameter int DEPTH = 10000,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [WW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [CW-1:0] vb_lines,
  input  logic [CW-1:0] hb_pix,
  input  logic [CW-1:0] aip,
  input  logic [CW-1:0] ail,
  input  logic          cs_display,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic          hblank,
  output logic          vblank,
  output logic          frame_start,
  output logic [1:0]    buf_empty,
  output logic          underrun
);
  localparam int PPW = WW / DW;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = $clog2(DEPTH + 1);
  localparam int TW  = 2 * CW;
  localparam int XW  = (TW > PW) ? TW : PW;
  localparam int LW  = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2,
    S_HBLANK = 2'd3
  } state_t;

  logic [DW-1:0] bank_mem [2][DEPTH];

  state_t        state_q, state_d;
  logic          first_q, first_d;
  logic [CW-1:0] vb_q, vb_d, hb_q, hb_d, aip_q, aip_d, ail_q, ail_d;
  logic [LW-1:0] col_q, col_d;
  logic [CW-1:0] line_q, line_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_sel_q, rd_sel_d;
  logic          wr_sel_q, wr_sel_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0] wr_total_q, wr_total_d;
  logic [1:0]    buf_empty_q, buf_empty_d;
  logic          underrun_q, underrun_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;

  logic          wr_accept, wr_done;
  logic [TW-1:0] wr_target;
  logic [XW-1:0] wr_ptr_next;
  logic          rel_bank, line_end, frame_end, go;
  logic [LW-1:0] line_last, act_last;
  logic [DW-1:0] rd_pix;

  // Write side: the frame size is captured at the first word of each bank.
  always_comb begin
    wr_accept   = wr_valid && buf_empty_q[wr_sel_q];
    wr_target   = (wr_ptr_q == '0) ? (TW'(aip) * TW'(ail)) : wr_total_q;
    wr_ptr_next = XW'(wr_ptr_q) + XW'(PPW);
    wr_done     = wr_accept && (wr_ptr_next >= XW'(wr_target));
    wr_ptr_d    = wr_ptr_q;
    wr_total_d  = wr_total_q;
    wr_sel_d    = wr_sel_q;
    if (wr_accept) begin
      wr_total_d = wr_target;
      if (wr_done) begin
        wr_ptr_d = '0;
        wr_sel_d = ~wr_sel_q;
      end else begin
        wr_ptr_d = PW'(wr_ptr_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int p = 0; p < PPW; p++) begin
        bank_mem[wr_sel_q][AW'(wr_ptr_q + PW'(p))] <= wr_data[p*DW +: DW];
      end
    end
  end

  assign line_last = {1'b0, aip_q} + {1'b0, hb_q} - LW'(1);
  assign act_last  = {1'b0, aip_q} - LW'(1);
  assign go        = cs_display && (aip != '0) && (ail != '0);
  assign rd_pix    = bank_mem[rd_sel_q][AW'(rd_ptr_q)];

  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    col_d      = col_q;
    line_d     = line_q;
    rd_ptr_d   = rd_ptr_q;
    rd_sel_d   = rd_sel_q;
    underrun_d = underrun_q;
    vb_d       = vb_q;
    hb_d       = hb_q;
    aip_d      = aip_q;
    ail_d      = ail_q;
    rel_bank   = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_VBLANK: begin
        if (col_q == line_last) begin
          col_d = '0;
          if (line_q == vb_q - CW'(1)) begin
            line_d  = '0;
            state_d = S_ACTIVE;
          end else begin
            line_d = line_q + CW'(1);
          end
        end else begin
          col_d = col_q + LW'(1);
        end
      end
      S_ACTIVE: begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (col_q == line_last) begin
          line_end = 1'b1;
        end else begin
          col_d = col_q + LW'(1);
          if (col_q == act_last) state_d = S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (col_q == line_last) line_end = 1'b1;
        else                    col_d = col_q + LW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (line_end) begin
      col_d = '0;
      if (line_q == ail_q - CW'(1)) begin
        frame_end = 1'b1;
      end else begin
        line_d  = line_q + CW'(1);
        state_d = S_ACTIVE;
      end
    end

    // Swap to the other bank only if it is ready; otherwise rescan this one.
    if (frame_end) begin
      state_d = S_IDLE;
      if (!buf_empty_q[~rd_sel_q]) begin
        rel_bank = 1'b1;
        rd_sel_d = ~rd_sel_q;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (go && (frame_end || (state_q == S_IDLE && !buf_empty_q[rd_sel_q]))) begin
      vb_d     = vb_lines;
      hb_d     = hb_pix;
      aip_d    = aip;
      ail_d    = ail;
      state_d  = (vb_lines != '0) ? S_VBLANK : S_ACTIVE;
      first_d  = 1'b1;
      col_d    = '0;
      line_d   = '0;
      rd_ptr_d = '0;
    end
  end

  always_comb begin
    buf_empty_d = buf_empty_q;
    if (wr_done)  buf_empty_d[wr_sel_q] = 1'b0;
    if (rel_bank) buf_empty_d[rd_sel_q] = 1'b1;
  end

  always_comb begin
    pix_valid_d   = (state_q == S_ACTIVE);
    pix_data_d    = (state_q == S_ACTIVE) ? rd_pix : pix_data_q;
    vblank_d      = (state_q == S_VBLANK);
    hblank_d      = (state_q == S_HBLANK) ||
                    ((state_q == S_VBLANK) && (col_q >= {1'b0, aip_q}));
    frame_start_d = first_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      first_q       <= 1'b0;
      vb_q          <= '0;
      hb_q          <= '0;
      aip_q         <= '0;
      ail_q         <= '0;
      col_q         <= '0;
      line_q        <= '0;
      rd_ptr_q      <= '0;
      rd_sel_q      <= 1'b0;
      wr_sel_q      <= 1'b0;
      wr_ptr_q      <= '0;
      wr_total_q    <= '0;
      buf_empty_q   <= 2'b11;
      underrun_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      vb_q          <= vb_d;
      hb_q          <= hb_d;
      aip_q         <= aip_d;
      ail_q         <= ail_d;
      col_q         <= col_d;
      line_q        <= line_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_sel_q      <= rd_sel_d;
      wr_sel_q      <= wr_sel_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_total_q    <= wr_total_d;
      buf_empty_q   <= buf_empty_d;
      underrun_q    <= underrun_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_ready    = buf_empty_q[wr_sel_q];
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;
  assign buf_empty   = buf_empty_q;
  assign underrun    = underrun_q;

endmodule
`default_nettype wire
